phys_reg_free_list: RTL and testbench

- Circular free list of physical register tags feeding the register renaming unit.
- Supplies one free physical destination tag per cycle to rename.
- Reclaims stale tags released by ROB commit.
- On pipeline flush, restores the speculative allocation pointer to the committed point in one cycle.

---
 rtl/phys_reg_free_list.sv | 119 +++++++++++
 tb/tb_phys_reg_free_list.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/phys_reg_free_list.sv
// Circular free list of physical register tags for rename, with commit-point flush recovery.
// Optional duplicate/protocol checker enabled by defining FREELIST_DUP_CHECK_EN.
module phys_reg_free_list #(
    parameter int NUM_PREG = 64,
    parameter int NUM_AREG = 32,
    parameter int DEPTH    = NUM_PREG - NUM_AREG,
    parameter int PREG_W   = $clog2(NUM_PREG)
) (
    input  logic                     CLK,
    input  logic                     RSTn,
    input  logic                     alloc_req_i,
    output logic                     alloc_valid_o,
    output logic [PREG_W-1:0]        alloc_preg_o,
    input  logic                     commit_i,
    input  logic                     release_valid_i,
    input  logic [PREG_W-1:0]        release_preg_i,
    input  logic                     flush_i,
    output logic [$clog2(DEPTH):0]   free_cnt_o,
    output logic                     err_o
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [PREG_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_spec_head;
    logic [PTR_W-1:0]  r_commit_head;
    logic [PTR_W-1:0]  r_tail;

    logic              w_alloc_fire;
    logic              w_commit_fire;
    logic              w_rel_full;
    logic              w_rel_fire;
    logic [PTR_W-1:0]  w_commit_head_next;
    logic [PTR_W-1:0]  w_spec_head_next;

    // Handshake: alloc_valid_o/alloc_preg_o depend only on state; a tag is taken in the
    // same cycle alloc_req_i is high while alloc_valid_o is high and no flush is present.
    assign free_cnt_o    = r_tail - r_spec_head;
    assign alloc_valid_o = (free_cnt_o != '0);
    assign alloc_preg_o  = r_mem[r_spec_head[IDX_W-1:0]];

    assign w_alloc_fire       = alloc_req_i && alloc_valid_o && !flush_i;
    assign w_commit_fire      = commit_i && (r_commit_head != r_spec_head);
    assign w_rel_full         = ((r_tail - r_commit_head) == PTR_W'(DEPTH));
    assign w_rel_fire         = release_valid_i && (release_preg_i != '0) && !w_rel_full;
    assign w_commit_head_next = r_commit_head + PTR_W'(w_commit_fire);
    assign w_spec_head_next   = flush_i ? w_commit_head_next
                                        : (r_spec_head + PTR_W'(w_alloc_fire));

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= PREG_W'(NUM_AREG + i);
            end
            r_spec_head   <= '0;
            r_commit_head <= '0;
            r_tail        <= PTR_W'(DEPTH);
        end else begin
            if (w_rel_fire) begin
                r_mem[r_tail[IDX_W-1:0]] <= release_preg_i;
                r_tail                   <= r_tail + PTR_W'(1);
            end
            r_commit_head <= w_commit_head_next;
            r_spec_head   <= w_spec_head_next;
        end
    end

`ifdef FREELIST_DUP_CHECK_EN
    localparam logic [NUM_PREG-1:0] FREE_RST = {{(NUM_PREG-NUM_AREG){1'b1}}, {NUM_AREG{1'b0}}};

    logic [NUM_PREG-1:0] r_is_free;
    logic [NUM_PREG-1:0] w_is_free_next;
    logic [PTR_W-1:0]    w_flush_len;
    logic [PTR_W-1:0]    w_flush_ptr;
    logic                w_err_set;
    logic                r_err;

    // Tags speculatively handed out past the commit point return to the free set on flush.
    always_comb begin
        w_is_free_next = r_is_free;
        w_flush_len    = r_spec_head - w_commit_head_next;
        w_flush_ptr    = '0;
        if (w_alloc_fire) begin
            w_is_free_next[alloc_preg_o] = 1'b0;
        end
        if (flush_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                w_flush_ptr = w_commit_head_next + PTR_W'(i);
                if (PTR_W'(i) < w_flush_len) begin
                    w_is_free_next[r_mem[w_flush_ptr[IDX_W-1:0]]] = 1'b1;
                end
            end
        end
        if (w_rel_fire) begin
            w_is_free_next[release_preg_i] = 1'b1;
        end
    end

    assign w_err_set = (release_valid_i && ((release_preg_i == '0) ||
                                            r_is_free[release_preg_i] || w_rel_full)) ||
                       (commit_i && (r_commit_head == r_spec_head));

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_is_free <= FREE_RST;
            r_err     <= 1'b0;
        end else begin
            r_is_free <= w_is_free_next;
            r_err     <= r_err || w_err_set;
        end
    end

    assign err_o = r_err;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Bench for phys_reg_free_list: vector table, directed corner sequences and a
// randomized run against a queue-based reference model.
module tb_phys_reg_free_list;

  localparam int NUM_PREG = 64;
  localparam int NUM_AREG = 32;
  localparam int DEPTH    = 32;
  localparam int PREG_W   = 6;
  localparam int CNT_W    = 6;
`ifdef FREELIST_DUP_CHECK_EN
  localparam bit DUP = 1'b1;
`else
  localparam bit DUP = 1'b0;
`endif

  // ---------------- clock / reset / dut ----------------
  logic              CLK = 1'b0;
  logic              RSTn = 1'b0;
  logic              alloc_req_i = 1'b0;
  logic              alloc_valid_o;
  logic [PREG_W-1:0] alloc_preg_o;
  logic              commit_i = 1'b0;
  logic              release_valid_i = 1'b0;
  logic [PREG_W-1:0] release_preg_i = '0;
  logic              flush_i = 1'b0;
  logic [CNT_W-1:0]  free_cnt_o;
  logic              err_o;

  always #5 CLK = ~CLK;

  phys_reg_free_list #(.NUM_PREG(NUM_PREG), .NUM_AREG(NUM_AREG)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .alloc_req_i(alloc_req_i), .alloc_valid_o(alloc_valid_o), .alloc_preg_o(alloc_preg_o),
    .commit_i(commit_i), .release_valid_i(release_valid_i), .release_preg_i(release_preg_i),
    .flush_i(flush_i), .free_cnt_o(free_cnt_o), .err_o(err_o)
  );

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input bit a, input bit c, input bit rv, input int rp, input bit f);
    alloc_req_i     = a;
    commit_i        = c;
    release_valid_i = rv;
    release_preg_i  = PREG_W'(rp);
    flush_i         = f;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RSTn = 1'b0;
    drive(0, 0, 0, 0, 0);
    repeat (2) @(negedge CLK);
    RSTn = 1'b1;
  endtask

  // ---------------- reference model ----------------
  // q holds tags from the commit point to the tail; the first n_inf are allocated
  // but not yet committed.
  int q[$];
  int n_inf;
  bit m_free[NUM_PREG];
  bit m_err;

  function automatic void model_reset();
    q.delete();
    for (int i = 0; i < DEPTH; i++) q.push_back(NUM_AREG + i);
    n_inf = 0;
    for (int i = 0; i < NUM_PREG; i++) m_free[i] = (i >= NUM_AREG);
    m_err = 0;
  endfunction

  function automatic void model_step(input bit a, input bit c, input bit rv, input int rp, input bit f);
    int cnt = q.size() - n_inf;
    bit af = a && (cnt > 0) && !f;
    bit cf = c && (n_inf > 0);
    bit rf = rv && (rp != 0) && (q.size() < DEPTH);
    if (rv && (rp == 0 || m_free[rp] || q.size() == DEPTH)) m_err = 1;
    if (c && n_inf == 0) m_err = 1;
    if (af) m_free[q[n_inf]] = 0;
    if (cf) begin
      void'(q.pop_front());
      n_inf--;
    end
    if (af) n_inf++;
    if (f) begin
      for (int i = 0; i < n_inf; i++) m_free[q[i]] = 1;
      n_inf = 0;
    end
    if (rf) begin
      q.push_back(rp);
      m_free[rp] = 1;
    end
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    bit a; bit c; bit rv; int rp; bit f;
    bit ev; int ep; int ec;
  } vec_t;

  vec_t tv[19];

  initial begin
    #500000;
    $display("FAIL timeout actual=%0d required=%0d", checks, 0);
    $fatal(1, "timeout");
  end

  initial begin
    // Expected values are the outputs seen during the cycle the inputs are applied.
    tv[0]  = '{0,0,0, 0,0, 1,32,32};
    tv[1]  = '{1,0,0, 0,0, 1,32,32};
    tv[2]  = '{1,0,0, 0,0, 1,33,31};
    tv[3]  = '{1,0,0, 0,0, 1,34,30};
    tv[4]  = '{1,0,0, 0,0, 1,35,29};
    tv[5]  = '{1,0,0, 0,0, 1,36,28};
    tv[6]  = '{0,1,0, 0,0, 1,37,27};
    tv[7]  = '{0,1,0, 0,0, 1,37,27};
    tv[8]  = '{0,0,0, 0,1, 1,37,27};
    tv[9]  = '{0,0,0, 0,0, 1,34,30};
    tv[10] = '{1,0,0, 0,0, 1,34,30};
    tv[11] = '{1,0,0, 0,0, 1,35,29};
    tv[12] = '{1,0,0, 0,0, 1,36,28};
    tv[13] = '{0,1,0, 0,1, 1,37,27};
    tv[14] = '{0,0,0, 0,0, 1,35,29};
    tv[15] = '{0,0,1, 0,0, 1,35,29};
    tv[16] = '{0,0,1,45,0, 1,35,29};
    tv[17] = '{1,0,1,46,0, 1,35,30};
    tv[18] = '{0,0,0, 0,0, 1,36,30};

    // reset state
    do_reset();
    @(negedge CLK);
    chk("rst_valid", alloc_valid_o, 1);
    chk("rst_preg", alloc_preg_o, 32);
    chk("rst_cnt", free_cnt_o, 32);
    chk("rst_err", err_o, 0);

    // table-driven sequence: alloc, commit, flush, flush+commit, releases
    for (int i = 0; i < 19; i++) begin
      @(negedge CLK);
      chk($sformatf("tv%0d_valid", i), alloc_valid_o, tv[i].ev);
      chk($sformatf("tv%0d_preg", i), alloc_preg_o, tv[i].ep);
      chk($sformatf("tv%0d_cnt", i), free_cnt_o, tv[i].ec);
      drive(tv[i].a, tv[i].c, tv[i].rv, tv[i].rp, tv[i].f);
    end

    // release while full is dropped
    do_reset();
    @(negedge CLK);
    drive(0, 0, 1, 50, 0);
    @(negedge CLK);
    drive(0, 0, 0, 0, 0);
    chk("full_rel_cnt", free_cnt_o, 32);
    chk("full_rel_preg", alloc_preg_o, 32);
    chk("full_rel_err", err_o, DUP);

    // drain all 32 tags, then over-request, then release into an empty list
    do_reset();
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(32'(NUM_AREG + i));
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge CLK);
      chk("drain_valid", alloc_valid_o, 1);
      chk("drain_preg", alloc_preg_o, exp_q.pop_front());
      drive(1, 0, 0, 0, 0);
    end
    @(negedge CLK);
    chk("empty_valid", alloc_valid_o, 0);
    chk("empty_cnt", free_cnt_o, 0);
    @(negedge CLK);
    chk("over_req_valid", alloc_valid_o, 0);
    chk("over_req_cnt", free_cnt_o, 0);
    drive(0, 1, 0, 0, 0);
    @(negedge CLK);
    drive(0, 0, 1, 40, 0);
    chk("rel_same_cycle_valid", alloc_valid_o, 0);
    @(negedge CLK);
    drive(0, 0, 0, 0, 0);
    chk("rel_next_valid", alloc_valid_o, 1);
    chk("rel_next_preg", alloc_preg_o, 40);
    chk("rel_next_cnt", free_cnt_o, 1);

    // duplicate release of a still-free tag
    do_reset();
    @(negedge CLK);
    drive(1, 0, 0, 0, 0);
    @(negedge CLK);
    drive(0, 1, 0, 0, 0);
    @(negedge CLK);
    chk("dup_pre_err", err_o, 0);
    drive(0, 0, 1, 33, 0);
    @(negedge CLK);
    drive(0, 0, 0, 0, 0);
    chk("dup_err", err_o, DUP);
    repeat (3) @(negedge CLK);
    chk("dup_err_held", err_o, DUP);

    // randomized run against the model, with periodic resets
    for (int blk = 0; blk < 6; blk++) begin
      do_reset();
      model_reset();
      for (int cyc = 0; cyc < 300; cyc++) begin
        bit a, c, rv, f;
        int rp;
        int cnt;
        @(negedge CLK);
        cnt = q.size() - n_inf;
        chk("rnd_valid", alloc_valid_o, (cnt != 0));
        chk("rnd_cnt", free_cnt_o, cnt);
        if (cnt != 0) chk("rnd_preg", alloc_preg_o, q[n_inf]);
        chk("rnd_err", err_o, DUP ? m_err : 1'b0);
        a  = ($urandom_range(0, 99) < 60);
        c  = ($urandom_range(0, 99) < 35);
        rv = ($urandom_range(0, 99) < 35);
        rp = $urandom_range(0, NUM_PREG - 1);
        f  = ($urandom_range(0, 99) < 5);
        drive(a, c, rv, rp, f);
        model_step(a, c, rv, rp, f);
      end
    end

    // asynchronous reset in the middle of activity
    drive(1, 0, 0, 0, 0);
    @(posedge CLK);
    #2 RSTn = 1'b0;
    #1;
    chk("async_rst_valid", alloc_valid_o, 1);
    chk("async_rst_preg", alloc_preg_o, 32);
    chk("async_rst_cnt", free_cnt_o, 32);
    chk("async_rst_err", err_o, 0);
    drive(0, 0, 0, 0, 0);
    @(negedge CLK);
    RSTn = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
